// File: rtl/battle_pkg.sv
// battle_pkg: shared types and field constants for bullet, tank and hit-detection blocks.
`default_nettype none

package battle_pkg;

  typedef enum logic [1:0] {
    INACTIVE  = 2'b00,
    FLYING    = 2'b01,
    EXPLODING = 2'b10
  } bullet_state_t;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    RIGHT = 2'b01,
    DOWN  = 2'b10,
    LEFT  = 2'b11
  } dir_t;

  localparam logic [8:0] FIELD_MAX = 9'd416;
  localparam logic [8:0] TILE_SIZE = 9'd16;

  // Returns {clipped, value}: value forced into [0, hi], clipped set when forcing was needed.
  function automatic logic [9:0] clamp_axis(input logic signed [11:0] v, input logic [8:0] hi);
    if (v < 12'sd0) return {1'b1, 9'd0};
    if (v > $signed({3'b000, hi})) return {1'b1, hi};
    return {1'b0, v[8:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/bullet_next_pos.sv
// bullet_next_pos: steps a position along a direction and clamps the bullet box into the field.
`default_nettype none

module bullet_next_pos
  import battle_pkg::*;
#(
  parameter logic [8:0] Bullet_Size = 9'd4,
  parameter logic [8:0] Field_Max   = FIELD_MAX
) (
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  logic [1:0] dir,
  input  logic [9:0] step,
  output logic [8:0] next_x,
  output logic [8:0] next_y,
  output logic       out_of_field
);

  localparam logic [8:0] LIMIT = Field_Max - Bullet_Size;

  logic signed [11:0] raw_x;
  logic signed [11:0] raw_y;
  logic [9:0]         clamp_x;
  logic [9:0]         clamp_y;

  always_comb begin
    raw_x = $signed({2'b00, pos_x});
    raw_y = $signed({2'b00, pos_y});
    case (dir)
      UP:      raw_y = raw_y - $signed({2'b00, step});
      RIGHT:   raw_x = raw_x + $signed({2'b00, step});
      DOWN:    raw_y = raw_y + $signed({2'b00, step});
      default: raw_x = raw_x - $signed({2'b00, step});
    endcase
    // Both axes are checked so the same block can vet a spawn box near any edge.
    clamp_x = clamp_axis(raw_x, LIMIT);
    clamp_y = clamp_axis(raw_y, LIMIT);
  end

  assign next_x       = clamp_x[8:0];
  assign next_y       = clamp_y[8:0];
  assign out_of_field = clamp_x[9] | clamp_y[9];

endmodule

`default_nettype wire

// File: rtl/bullet_controller.sv
// bullet_controller: spawns, moves and retires one tank's bullet once per synchronised frame tick.
// Optional refire lockout enabled by defining BULLET_COOLDOWN_EN.
`default_nettype none

module bullet_controller
  import battle_pkg::*;
#(
  parameter logic [8:0] Bullet_Size     = 9'd4,
  parameter logic [8:0] Tank_Size       = TILE_SIZE,
  parameter logic [8:0] Bullet_Speed    = 9'd2,
  parameter logic [8:0] Field_Max       = FIELD_MAX,
  parameter logic [3:0] Explode_Frames  = 4'd8
`ifdef BULLET_COOLDOWN_EN
  ,
  parameter logic [4:0] Cooldown_Frames = 5'd16
`endif
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic [8:0] Tank_X,
  input  logic [8:0] Tank_Y,
  input  logic [1:0] Tank_Dir,
  input  logic       hit_bullet,
  input  logic       hit_wall,
  input  logic       hit_tank,
  output logic [8:0] Bullet_X,
  output logic [8:0] Bullet_Y,
  output logic [1:0] Bullet_State,
  output logic [1:0] Bullet_Dir
);

  // Spawn = tank box centred on the perpendicular axis, then pushed REACH along the facing.
  localparam logic [8:0] HALF_OFF = (Tank_Size - Bullet_Size) >> 1;
  localparam logic [8:0] REACH    = Tank_Size - HALF_OFF;

  logic [2:0]    sync_q, sync_d;
  logic          frame_tick;
  bullet_state_t state_q, state_d;
  logic [1:0]    dir_q, dir_d;
  logic [8:0]    x_q, x_d;
  logic [8:0]    y_q, y_d;
  logic [3:0]    explode_cnt_q, explode_cnt_d;
  logic          fire_pending_q, fire_pending_d;
  logic          spawn_ok;
`ifdef BULLET_COOLDOWN_EN
  logic [4:0]    cooldown_q, cooldown_d;
`endif

  logic [9:0] spawn_base_x;
  logic [9:0] spawn_base_y;
  logic [8:0] spawn_x, spawn_y;
  logic       spawn_oof;
  logic [8:0] move_x, move_y;
  logic       move_oof;

  assign spawn_base_x = {1'b0, Tank_X} + {1'b0, HALF_OFF};
  assign spawn_base_y = {1'b0, Tank_Y} + {1'b0, HALF_OFF};

  bullet_next_pos #(
    .Bullet_Size (Bullet_Size),
    .Field_Max   (Field_Max)
  ) u_spawn_pos (
    .pos_x        (spawn_base_x),
    .pos_y        (spawn_base_y),
    .dir          (Tank_Dir),
    .step         ({1'b0, REACH}),
    .next_x       (spawn_x),
    .next_y       (spawn_y),
    .out_of_field (spawn_oof)
  );

  bullet_next_pos #(
    .Bullet_Size (Bullet_Size),
    .Field_Max   (Field_Max)
  ) u_move_pos (
    .pos_x        ({1'b0, x_q}),
    .pos_y        ({1'b0, y_q}),
    .dir          (dir_q),
    .step         ({1'b0, Bullet_Speed}),
    .next_x       (move_x),
    .next_y       (move_y),
    .out_of_field (move_oof)
  );

  assign frame_tick = sync_q[1] & ~sync_q[2];

  always_comb begin
    sync_d         = {sync_q[1:0], frame_clk};
    state_d        = state_q;
    dir_d          = dir_q;
    x_d            = x_q;
    y_d            = y_q;
    explode_cnt_d  = explode_cnt_q;
    fire_pending_d = frame_tick ? 1'b0 : (fire_pending_q | fire);
`ifdef BULLET_COOLDOWN_EN
    cooldown_d     = cooldown_q;
    // The tick that brings the counter to zero is the first one allowed to spawn.
    spawn_ok       = (cooldown_q <= 5'd1);
`else
    spawn_ok       = 1'b1;
`endif

    if (frame_tick) begin
      case (state_q)
        INACTIVE: begin
`ifdef BULLET_COOLDOWN_EN
          if (cooldown_q != 5'd0) cooldown_d = cooldown_q - 5'd1;
`endif
          if ((fire_pending_q | fire) && spawn_ok) begin
            dir_d = Tank_Dir;
            x_d   = spawn_x;
            y_d   = spawn_y;
            if (spawn_oof) begin
              state_d       = EXPLODING;
              explode_cnt_d = Explode_Frames - 4'd1;
            end else begin
              state_d = FLYING;
            end
          end
        end
        FLYING: begin
          if (hit_bullet | hit_wall | hit_tank) begin
            state_d       = EXPLODING;
            explode_cnt_d = Explode_Frames - 4'd1;
          end else begin
            x_d = move_x;
            y_d = move_y;
            if (move_oof) begin
              state_d       = EXPLODING;
              explode_cnt_d = Explode_Frames - 4'd1;
            end
          end
        end
        EXPLODING: begin
          if (explode_cnt_q == 4'd0) begin
            state_d = INACTIVE;
`ifdef BULLET_COOLDOWN_EN
            cooldown_d = Cooldown_Frames;
`endif
          end else begin
            explode_cnt_d = explode_cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = INACTIVE;
`ifdef BULLET_COOLDOWN_EN
          cooldown_d = Cooldown_Frames;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q         <= 3'b000;
      state_q        <= INACTIVE;
      dir_q          <= 2'b00;
      x_q            <= 9'd0;
      y_q            <= 9'd0;
      explode_cnt_q  <= 4'd0;
      fire_pending_q <= 1'b0;
`ifdef BULLET_COOLDOWN_EN
      cooldown_q     <= 5'd0;
`endif
    end else begin
      sync_q         <= sync_d;
      state_q        <= state_d;
      dir_q          <= dir_d;
      x_q            <= x_d;
      y_q            <= y_d;
      explode_cnt_q  <= explode_cnt_d;
      fire_pending_q <= fire_pending_d;
`ifdef BULLET_COOLDOWN_EN
      cooldown_q     <= cooldown_d;
`endif
    end
  end

  assign Bullet_X     = x_q;
  assign Bullet_Y     = y_q;
  assign Bullet_State = state_q;
  assign Bullet_Dir   = dir_q;

endmodule

`default_nettype wire

// File: doc/bullet_controller.md
Name: bullet_controller

Overview:
Owns one bullet's lifecycle and produces the Bullet_X/Bullet_Y/Bullet_State triple that the hit-detection blocks consume. It spawns the bullet at the firing tank's muzzle and moves it once per frame. It retires the bullet through an explosion phase on any hit or at the field edge. One instance sits per tank, between tank control and the hit checkers, and feeds the sprite renderer.

Parameters:
Bullet_Size, 9'd4, bullet edge length in pixels
Tank_Size, 9'd16, tank edge length in pixels
Bullet_Speed, 9'd2, pixels moved per frame tick
Field_Max, 9'd416, exclusive upper bound of the play field on X and Y
Explode_Frames, 4'd8, frame ticks spent in EXPLODING
Cooldown_Frames, 5'd16, frame ticks of refire lockout (used only with the optional feature)

Ports:
Clk  input  1  system clock
Reset_n  input  1  asynchronous active-low reset
frame_clk  input  1  vertical-sync-derived frame pulse, asynchronous to Clk
fire  input  1  fire request from tank control, level or pulse
Tank_X, Tank_Y  input  9 each  firing tank top-left position
Tank_Dir  input  2  tank facing: 00 up, 01 right, 10 down, 11 left
hit_bullet  input  1  overlap with another live bullet
hit_wall  input  1  overlap with a destructible or steel tile
hit_tank  input  1  overlap with an enemy tank
Bullet_X, Bullet_Y  output  9 each  bullet top-left position
Bullet_State  output  2  00 INACTIVE, 01 FLYING, 10 EXPLODING, 11 reserved
Bullet_Dir  output  2  direction latched at spawn

Behaviour:
- Reset (Reset_n=0, asynchronous): all outputs are 0. Internal fire_pending, explode counter and cooldown counter are cleared. Synchroniser flops are cleared.
- Reset takes effect immediately mid-flight or mid-explosion. No partial state survives.
- frame_clk passes through a 2-flop synchroniser, then a rising-edge detect that forms frame_tick.
- frame_tick is exactly one Clk wide. All state and position updates occur only on frame_tick.
- Output latency is 3 Clk after a frame_clk rise.
- fire sets fire_pending on any Clk. fire_pending is cleared on every frame_tick, whether or not it was used.
- INACTIVE, on a tick with fire_pending:
  - Latch Bullet_Dir=Tank_Dir and spawn at an offset of (Tank_Size-Bullet_Size)/2 = 6 on the perpendicular axis.
  - up: (Tank_X+6, Tank_Y-4)
  - right: (Tank_X+16, Tank_Y+6)
  - down: (Tank_X+6, Tank_Y+16)
  - left: (Tank_X-4, Tank_Y+6)
  - Spawn arithmetic uses 10-bit intermediates. If the spawn box falls outside [0, Field_Max), position is clamped inside the field and state goes directly to EXPLODING. Otherwise state goes to FLYING.
- FLYING, on a tick:
  - If hit_bullet|hit_wall|hit_tank: go to EXPLODING, position frozen. Hits take priority over movement.
  - Else compute the next position with Bullet_Speed along Bullet_Dir in 10-bit arithmetic.
  - If next<0 or next+Bullet_Size>Field_Max: clamp to 0 or Field_Max-Bullet_Size and go to EXPLODING.
  - Otherwise move.
  - fire is ignored while FLYING: one bullet per instance.
- EXPLODING: load the counter with Explode_Frames-1 on entry and decrement per tick. At 0, go to INACTIVE on the next tick. Position is held. Hit inputs and fire are ignored.
- INACTIVE holds the last position. Renderers must key off Bullet_State.
- State 11 returns to INACTIVE on the next tick.
- A hit input arriving while not FLYING has no effect.
- Hit inputs are sampled only on frame_tick.

Optional Feature:
BULLET_COOLDOWN_EN
- Defined: entering INACTIVE loads the cooldown counter with Cooldown_Frames. It decrements per tick, and fire_pending cannot spawn until it reaches 0.
- Undefined: a spawn is permitted on the first tick after INACTIVE is entered. No cooldown counter exists.

Decomposition:
- Package battle_pkg holds:
  - bullet_state_t enum: INACTIVE, FLYING, EXPLODING
  - dir_t enum: UP, RIGHT, DOWN, LEFT
  - FIELD_MAX, TILE_SIZE constants, shared with tank and hit blocks
- Sub-module bullet_next_pos: combinational. Takes position, direction and speed; returns the clamped next position plus an out_of_field flag. It is reused for spawn offset checks.

Test Plan:
- Reset: Reset_n low mid-FLYING at (200,150) -> outputs 0 and State 00 immediately; no movement on subsequent ticks until fire.
- Fire up: Tank (100,100), Dir 00, fire pulse, tick -> State 01, (106,96). Next tick -> (106,94).
- Edge exit: flying left at X=1 -> next tick State 10 at X=0. After 8 ticks -> State 00.
- Hit priority: flying right at (300,50) with hit_wall and fire high on the same tick -> State 10, position unchanged at (300,50), no respawn.
- Spawn outside field: Tank (0,0), Dir 11, fire -> State 10 directly at X=0. fire during EXPLODING is ignored.
- Cooldown (BULLET_COOLDOWN_EN): fire held continuously -> next spawn occurs exactly 16 ticks after INACTIVE is entered; without the macro -> spawn on the first tick after INACTIVE.
